bp_fe_icache_mem_responder: RTL and testbench

// Memory-side end of the I$ engine's mem_cmd/mem_resp interface, used as the backing store for I$ testbenches.

---
 rtl/bp_fe_icache_mem_responder.sv | 214 +++++++++++++++++++++
 tb/tb_bp_fe_icache_mem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_icache_mem_responder.sv
// Memory-side responder for the I$ engine's mem_cmd/mem_resp interface.
// It accepts one command at a time, holds mem_els_p cache blocks of storage and
// returns one response per command after latency_p cycles in WAIT.
//
// Message layout (MSB first): {msg_type, addr, size, payload, data}.
// The header is everything above the data field. It is echoed bit-for-bit in the
// response. Processor-config widths are exposed as individual parameters.
module bp_fe_icache_mem_responder #(
  parameter int paddr_width_p      = 40,
  parameter int cce_block_width_p  = 512,
  parameter int lce_id_width_p     = 4,
  parameter int lce_assoc_p        = 8,
  parameter int mem_els_p          = 1024,
  parameter int latency_p          = 4,
  localparam int msg_type_width_lp = 4,
  localparam int size_width_lp     = 3,
  localparam int payload_width_lp  = lce_id_width_p + $clog2(lce_assoc_p),
  localparam int hdr_width_lp      = msg_type_width_lp + paddr_width_p + size_width_lp + payload_width_lp,
  localparam int cce_mem_msg_width_lp = hdr_width_lp + cce_block_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_yumi_i
);

  // Geometry of a block and of the storage array
  localparam int block_bytes_lp = cce_block_width_p / 8;
  localparam int off_width_lp   = $clog2(block_bytes_lp);
  localparam int idx_width_lp   = $clog2(mem_els_p);
  localparam int cnt_width_lp   = (latency_p > 1) ? $clog2(latency_p) : 1;

  // Field positions inside the header
  localparam int size_lsb_lp = payload_width_lp;
  localparam int addr_lsb_lp = size_lsb_lp + size_width_lp;
  localparam int type_lsb_lp = addr_lsb_lp + paddr_width_p;

  // Message type encodings
  localparam logic [msg_type_width_lp-1:0] e_mem_msg_rd    = 4'd0;
  localparam logic [msg_type_width_lp-1:0] e_mem_msg_wr    = 4'd1;
  localparam logic [msg_type_width_lp-1:0] e_mem_msg_uc_rd = 4'd2;
  localparam logic [msg_type_width_lp-1:0] e_mem_msg_uc_wr = 4'd3;

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [hdr_width_lp-1:0]      r_hdr;
  logic [cnt_width_lp-1:0]      r_cnt;
  logic [cce_block_width_p-1:0] r_rd_data;
  logic [cce_block_width_p-1:0] r_mem [0:mem_els_p-1];

  // Incoming command fields
  logic [hdr_width_lp-1:0]      w_cmd_hdr;
  logic [cce_block_width_p-1:0] w_cmd_data;
  logic [msg_type_width_lp-1:0] w_cmd_type;
  logic [size_width_lp-1:0]     w_cmd_size;
  logic [idx_width_lp-1:0]      w_cmd_idx;
  logic [off_width_lp-1:0]      w_cmd_off;
  logic [off_width_lp:0]        w_cmd_nbytes;
  logic                         w_cmd_is_uc;

  // Latched command fields
  logic [msg_type_width_lp-1:0] w_hdr_type;
  logic [size_width_lp-1:0]     w_hdr_size;
  logic [idx_width_lp-1:0]      w_hdr_idx;
  logic [off_width_lp-1:0]      w_hdr_off;
  logic [off_width_lp:0]        w_hdr_nbytes;
  logic                         w_hdr_is_read;

  logic                         w_accept;
  logic                         w_wr_en;
  logic                         w_rd_en;
  logic [cce_block_width_p-1:0] w_wdata;
  logic [block_bytes_lp-1:0]    w_be;
  logic [cce_block_width_p-1:0] w_uc_data;
  logic [cce_block_width_p-1:0] w_resp_data;

  // Uncached transfer length in bytes: 2^size, clamped to one block
  function automatic logic [off_width_lp:0] f_nbytes(input logic [size_width_lp-1:0] size);
    if (int'(size) >= off_width_lp) begin
      return (off_width_lp+1)'(block_bytes_lp);
    end
    return (off_width_lp+1)'(1) << size;
  endfunction

  assign w_cmd_hdr    = mem_cmd_i[cce_mem_msg_width_lp-1:cce_block_width_p];
  assign w_cmd_data   = mem_cmd_i[cce_block_width_p-1:0];
  assign w_cmd_type   = w_cmd_hdr[type_lsb_lp +: msg_type_width_lp];
  assign w_cmd_size   = w_cmd_hdr[size_lsb_lp +: size_width_lp];
  assign w_cmd_idx    = w_cmd_hdr[addr_lsb_lp + off_width_lp +: idx_width_lp];
  assign w_cmd_off    = w_cmd_hdr[addr_lsb_lp +: off_width_lp];
  assign w_cmd_nbytes = f_nbytes(w_cmd_size);
  assign w_cmd_is_uc  = (w_cmd_type == e_mem_msg_uc_wr);

  assign w_hdr_type    = r_hdr[type_lsb_lp +: msg_type_width_lp];
  assign w_hdr_size    = r_hdr[size_lsb_lp +: size_width_lp];
  assign w_hdr_idx     = r_hdr[addr_lsb_lp + off_width_lp +: idx_width_lp];
  assign w_hdr_off     = r_hdr[addr_lsb_lp +: off_width_lp];
  assign w_hdr_nbytes  = f_nbytes(w_hdr_size);
  assign w_hdr_is_read = (w_hdr_type == e_mem_msg_rd) || (w_hdr_type == e_mem_msg_uc_rd);

  // Writes commit on the accept edge. A later read to the same index therefore
  // always sees the new data.
  assign w_accept = mem_cmd_v_i & mem_cmd_ready_o;
  assign w_wr_en  = w_accept & ((w_cmd_type == e_mem_msg_wr) || (w_cmd_type == e_mem_msg_uc_wr));

  // The array read is issued on the last WAIT edge so that data is registered in RESP
  assign w_rd_en = (r_state == S_WAIT) && (r_cnt == '0) && w_hdr_is_read;

  // Write lanes: an uncached write rotates payload byte k to block byte (off+k) mod
  // block size. A range that overruns the block therefore wraps to its start.
  for (genvar gi = 0; gi < block_bytes_lp; gi++) begin : g_wr_lane
    logic [off_width_lp-1:0] w_src;
    assign w_src = off_width_lp'(gi) - w_cmd_off;
    assign w_wdata[8*gi +: 8] = w_cmd_is_uc ? w_cmd_data[8*w_src +: 8] : w_cmd_data[8*gi +: 8];
    assign w_be[gi]           = w_cmd_is_uc ? ({1'b0, w_src} < w_cmd_nbytes) : 1'b1;
  end

  // Read lanes: an uncached read returns block byte (off+k) mod block size in lane k.
  // Lanes at or beyond the transfer length are zero.
  for (genvar gi = 0; gi < block_bytes_lp; gi++) begin : g_rd_lane
    logic [off_width_lp-1:0] w_src;
    assign w_src = w_hdr_off + off_width_lp'(gi);
    assign w_uc_data[8*gi +: 8] = ({1'b0, off_width_lp'(gi)} < w_hdr_nbytes) ? r_rd_data[8*w_src +: 8] : 8'h00;
  end

  // Response data by message type; writes and unknown types return zero
  always_comb begin
    w_resp_data = '0;
    case (w_hdr_type)
      e_mem_msg_rd:    w_resp_data = r_rd_data;
      e_mem_msg_uc_rd: w_resp_data = w_uc_data;
      default:         w_resp_data = '0;
    endcase
  end

  // Block storage: byte-enabled write on accept, registered whole-block read.
  // The contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int b = 0; b < block_bytes_lp; b++) begin
        if (w_be[b]) begin
          r_mem[w_cmd_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
    if (w_rd_en) begin
      r_rd_data <= r_mem[w_hdr_idx];
    end
  end

  // Header capture on accept; this is echoed unchanged in the response
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_hdr <= '0;
    end else if (w_accept) begin
      r_hdr <= w_cmd_hdr;
    end
  end

  // Latency counter: loaded on accept, counts down to zero while in WAIT
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= cnt_width_lp'(latency_p - 1);
    end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // FSM state register; reset drops any pending command
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_READY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: READY -> WAIT on a command, WAIT -> RESP at count zero,
  // and RESP -> READY when the consumer takes the response
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_READY: if (mem_cmd_v_i)     w_state_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0)     w_state_next = S_RESP;
      S_RESP:  if (mem_resp_yumi_i) w_state_next = S_READY;
      default:                      w_state_next = S_READY;
    endcase
  end

  // FSM outputs. These are held quiet while reset is asserted. The response is
  // zero outside RESP.
  always_comb begin
    mem_cmd_ready_o = (r_state == S_READY) && !reset_i;
    mem_resp_v_o    = (r_state == S_RESP)  && !reset_i;
    mem_resp_o      = '0;
    if (mem_resp_v_o) begin
      mem_resp_o = {r_hdr, w_resp_data};
    end
  end

endmodule

// File: tb/tb_bp_fe_icache_mem_responder.sv
// Directed test of bp_fe_icache_mem_responder with a scoreboard of expected responses.
module tb_bp_fe_icache_mem_responder;
  localparam int BW  = 512;
  localparam int MW  = 566;
  localparam int LAT = 4;
  localparam logic [3:0] T_RD   = 4'd0;
  localparam logic [3:0] T_WR   = 4'd1;
  localparam logic [3:0] T_UCRD = 4'd2;
  localparam logic [3:0] T_UCWR = 4'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic [MW-1:0] mem_cmd_i;
  logic          mem_cmd_v_i;
  logic          mem_cmd_ready_o;
  logic [MW-1:0] mem_resp_o;
  logic          mem_resp_v_o;
  logic          mem_resp_yumi_i;

  int total = 0;
  int bad   = 0;

  logic [MW-1:0] exp_q [$];
  logic [BW-1:0] mdl [0:1023];

  always #5 clk = ~clk;

  bp_fe_icache_mem_responder dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .mem_cmd_i       (mem_cmd_i),
    .mem_cmd_v_i     (mem_cmd_v_i),
    .mem_cmd_ready_o (mem_cmd_ready_o),
    .mem_resp_o      (mem_resp_o),
    .mem_resp_v_o    (mem_resp_v_o),
    .mem_resp_yumi_i (mem_resp_yumi_i)
  );

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-wise view of the backing store
  function automatic logic [BW-1:0] model(input logic [3:0] t, input logic [39:0] a,
                                          input logic [2:0] s, input logic [BW-1:0] d);
    logic [BW-1:0] r;
    int idx, off, nb;
    r   = '0;
    idx = int'(a[15:6]);
    off = int'(a[5:0]);
    nb  = (s >= 3'd6) ? 64 : (1 << s);
    case (t)
      T_RD:   r = mdl[idx];
      T_WR:   mdl[idx] = d;
      T_UCRD: for (int k = 0; k < nb; k++) r[8*k +: 8] = mdl[idx][8*((off + k) % 64) +: 8];
      T_UCWR: for (int k = 0; k < nb; k++) mdl[idx][8*((off + k) % 64) +: 8] = d[8*k +: 8];
      default: r = '0;
    endcase
    return r;
  endfunction

  // Present one command; returns at the negedge just after the accept edge
  task automatic issue(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                       input logic [6:0] p, input logic [BW-1:0] d);
    int n = 0;
    while (mem_cmd_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready", mem_cmd_ready_o, 1'b1);
    exp_q.push_back({t, a, s, p, model(t, a, s, d)});
    mem_cmd_i   = {t, a, s, p, d};
    mem_cmd_v_i = 1'b1;
    @(negedge clk);
    mem_cmd_v_i = 1'b0;
    mem_cmd_i   = '0;
  endtask

  // Wait for the response, check latency/content/stability, then take it
  task automatic collect(input int hold, output logic [MW-1:0] got);
    int lat = 1;
    logic [MW-1:0] exp;
    while (mem_resp_v_o !== 1'b1 && lat < 40) begin
      check("ready_low_wait", mem_cmd_ready_o, 1'b0);
      @(negedge clk);
      lat++;
    end
    check("resp_latency", lat, LAT + 1);
    got = mem_resp_o;
    check("sb_depth", exp_q.size(), 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("resp_msg", got, exp);
    for (int i = 0; i < hold; i++) begin
      check("ready_low_resp", mem_cmd_ready_o, 1'b0);
      @(negedge clk);
      check("hold_v", mem_resp_v_o, 1'b1);
      check("hold_stable", mem_resp_o, got);
    end
    check("ready_low_resp", mem_cmd_ready_o, 1'b0);
    mem_resp_yumi_i = 1'b1;
    @(negedge clk);
    mem_resp_yumi_i = 1'b0;
    check("ready_after_yumi", mem_cmd_ready_o, 1'b1);
    check("v_after_yumi", mem_resp_v_o, 1'b0);
    $display("txn hdr=%0h data=%0h", got[MW-1:BW], got[BW-1:0]);
  endtask

  // yumi is only legal while a response is valid
  always @(posedge clk) begin
    if (mem_resp_yumi_i === 1'b1) check("yumi_legal", mem_resp_v_o, 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [MW-1:0] got;
    logic [BW-1:0] pat;
    logic [BW-1:0] zero_blk;
    logic [BW-1:0] exp_d;

    zero_blk        = '0;
    reset           = 1'b1;
    mem_cmd_v_i     = 1'b0;
    mem_cmd_i       = '0;
    mem_resp_yumi_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", mem_cmd_ready_o, 1'b0);
    check("reset_v", mem_resp_v_o, 1'b0);
    check("reset_resp", mem_resp_o, '0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", mem_cmd_ready_o, 1'b1);

    // Block write then read
    pat = {64{8'hA5}};
    issue(T_WR, 40'h80_0000_0040, 3'd6, 7'h15, pat);
    collect(0, got);
    check("wr_ack_data", got[BW-1:0], '0);
    issue(T_RD, 40'h80_0000_0040, 3'd6, 7'h2A, '0);
    collect(0, got);
    check("rd_a5", got[BW-1:0], pat);

    // Uncached word write/read into a zeroed block
    issue(T_WR, 40'h80_0000_0040, 3'd6, 7'h01, zero_blk);
    collect(0, got);
    issue(T_UCWR, 40'h80_0000_0044, 3'd2, 7'h02, BW'(32'hDEAD_BEEF));
    collect(0, got);
    issue(T_UCRD, 40'h80_0000_0044, 3'd2, 7'h03, '0);
    collect(0, got);
    check("uc_rd_word", got[BW-1:0], BW'(32'hDEAD_BEEF));
    issue(T_RD, 40'h80_0000_0040, 3'd6, 7'h04, '0);
    collect(0, got);
    exp_d = BW'(32'hDEAD_BEEF) << 32;
    check("blk_word1", got[BW-1:0], exp_d);

    // Uncached accesses that overrun the block end wrap to its start
    issue(T_UCWR, 40'h80_0000_007E, 3'd2, 7'h05, BW'(32'h1122_3344));
    collect(0, got);
    issue(T_UCRD, 40'h80_0000_007E, 3'd2, 7'h06, '0);
    collect(0, got);
    check("uc_wrap_rd", got[BW-1:0], BW'(32'h1122_3344));
    issue(T_UCRD, 40'h80_0000_0040, 3'd1, 7'h07, '0);
    collect(0, got);
    check("uc_half_rd", got[BW-1:0], BW'(16'h1122));
    issue(T_UCRD, 40'h80_0000_0044, 3'd6, 7'h08, '0);
    collect(0, got);

    // Backpressure: response held for 20 cycles
    issue(T_RD, 40'h80_0000_0040, 3'd6, 7'h09, '0);
    collect(20, got);

    // Index wrap across mem_els_p blocks
    pat = {16{$urandom()}};
    issue(T_WR, 40'h80_0000_0000, 3'd6, 7'h0A, pat);
    collect(0, got);
    issue(T_RD, 40'h80_0001_0000, 3'd6, 7'h0B, '0);
    collect(0, got);
    check("wrap_rd", got[BW-1:0], pat);

    // Unknown type: zero data and no storage change
    issue(4'd7, 40'h80_0000_0000, 3'd6, 7'h0C, ~pat);
    collect(0, got);
    issue(T_RD, 40'h80_0000_0000, 3'd6, 7'h0D, '0);
    collect(0, got);
    check("unk_no_write", got[BW-1:0], pat);

    // Reset while a read is waiting: its response is dropped
    issue(T_RD, 40'h80_0000_0040, 3'd6, 7'h0E, '0);
    void'(exp_q.pop_back());
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready", mem_cmd_ready_o, 1'b0);
    check("midrst_v", mem_resp_v_o, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", mem_cmd_ready_o, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("midrst_no_resp", mem_resp_v_o, 1'b0);
      @(negedge clk);
    end
    issue(T_RD, 40'h80_0000_0000, 3'd6, 7'h0F, '0);
    collect(0, got);
    check("post_rst_rd", got[BW-1:0], pat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
